// File: rtl/instr_decode.sv
// Instruction decoder with a 2-entry skid buffer on the output.
// Each instruction is fully decoded when it is accepted, and the decoded bundle is stored.
// The output registers therefore drive dec_* directly, with no logic after them.
module instr_decode #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [31:0]          instr_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic [3:0]           dec_op_o,
  output logic [4:0]           dec_ra_o,
  output logic [4:0]           dec_rb_o,
  output logic [4:0]           dec_wreg_o,
  output logic [DATAWIDTH-1:0] dec_off_o,
  output logic [1:0]           dec_class_o,
  output logic                 dec_we_o,
  output logic [15:0]          illegal_cnt_o
);

  localparam logic [3:0] ADD_OP = 4'd0;
  localparam logic [3:0] SUB_OP = 4'd1;
  localparam logic [3:0] MUL_OP = 4'd2;
  localparam logic [3:0] DIV_OP = 4'd3;
  localparam logic [3:0] AND_OP = 4'd4;
  localparam logic [3:0] OR_OP  = 4'd5;
  localparam logic [3:0] XOR_OP = 4'd6;
  localparam logic [3:0] LW_OP  = 4'd7;
  localparam logic [3:0] SW_OP  = 4'd8;
  localparam logic [3:0] BEQ_OP = 4'd9;
  localparam logic [3:0] BGT_OP = 4'd10;
  localparam logic [3:0] BGE_OP = 4'd11;

  localparam logic [1:0] ClsAlu = 2'd0;
  localparam logic [1:0] ClsMem = 2'd1;
  localparam logic [1:0] ClsJmp = 2'd2;
  localparam logic [1:0] ClsIll = 2'd3;

  typedef struct packed {
    logic [3:0]           op;
    logic [4:0]           ra;
    logic [4:0]           rb;
    logic [4:0]           wreg;
    logic [DATAWIDTH-1:0] off;
    logic [1:0]           cls;
    logic                 we;
  } bundle_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e       state_q, state_d;
  bundle_t      out_q, out_d, skid_q, skid_d, dec_new;
  logic         ready_q, ready_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [1:0]   raw_cls;
  logic         illegal;
  logic         accept, xfer;

  // Decode the incoming instruction into a bundle ready to be stored.
  always_comb begin
    unique case (instr_i[3:0])
      ADD_OP, SUB_OP, MUL_OP, DIV_OP, AND_OP, OR_OP, XOR_OP: raw_cls = ClsAlu;
      LW_OP, SW_OP:                                         raw_cls = ClsMem;
      BEQ_OP, BGT_OP, BGE_OP:                               raw_cls = ClsJmp;
      default:                                              raw_cls = ClsIll;
    endcase
    illegal = (raw_cls == ClsIll) ||
              (raw_cls == ClsAlu && instr_i[31:19] != 13'd0) ||
              ((raw_cls == ClsMem || raw_cls == ClsJmp) && instr_i[8:4] != 5'd0);

    dec_new      = '0;
    dec_new.op   = instr_i[3:0];
    dec_new.ra   = instr_i[18:14];
    dec_new.rb   = instr_i[13:9];
    if (illegal) begin
      dec_new.cls = ClsIll;
    end else begin
      dec_new.cls = raw_cls;
      if (raw_cls == ClsAlu) begin
        dec_new.wreg = instr_i[8:4];
        dec_new.we   = 1'b1;
      end else begin
        dec_new.off = {{(DATAWIDTH-13){instr_i[31]}}, instr_i[31:19]};
        if (instr_i[3:0] == LW_OP) begin
          dec_new.wreg = instr_i[13:9];
          dec_new.we   = 1'b1;
        end
      end
    end
  end

  assign accept = instr_valid_i && ready_q && !flush_i;
  assign xfer   = (state_q != StEmpty) && dec_ready_i;

  // Skid-buffer next state, data movement and illegal counter.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            out_d   = dec_new;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && !xfer) begin
            skid_d  = dec_new;
            state_d = StTwo;
          end else if (xfer && !accept) begin
            state_d = StEmpty;
          end else if (xfer && accept) begin
            out_d = dec_new;
          end
        end
        StTwo: begin
          if (xfer) begin
            out_d   = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
      if (xfer && out_q.cls == ClsIll && cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    ready_d = (state_d != StTwo);
  end

  // State registers; synchronous reset clears everything, including buffered data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_ready_o = ready_q;
  assign dec_valid_o   = (state_q != StEmpty);
  assign dec_op_o      = out_q.op;
  assign dec_ra_o      = out_q.ra;
  assign dec_rb_o      = out_q.rb;
  assign dec_wreg_o    = out_q.wreg;
  assign dec_off_o     = out_q.off;
  assign dec_class_o   = out_q.cls;
  assign dec_we_o      = out_q.we;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed scenarios plus a randomized run against a
// queue-based reference model.
module tb_instr_decode;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3, AND_ = 4'd4;
  localparam logic [3:0] OR_ = 4'd5, XOR_ = 4'd6, LW = 4'd7, SW = 4'd8;
  localparam logic [3:0] BEQ = 4'd9, BGT = 4'd10, BGE = 4'd11;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  wreg;
    logic [31:0] off;
    logic [1:0]  cls;
    logic        we;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, flush_i = 1'b0, instr_valid_i = 1'b0, dec_ready_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic        instr_ready_o, dec_valid_o, dec_we_o;
  logic [3:0]  dec_op_o;
  logic [4:0]  dec_ra_o, dec_rb_o, dec_wreg_o;
  logic [31:0] dec_off_o;
  logic [1:0]  dec_class_o;
  logic [15:0] illegal_cnt_o;
  bundle_t     dut_b;

  int checks = 0;
  int failures = 0;

  bundle_t q[$];
  int      exp_cnt = 0;
  bit      m_ready = 1'b1;

  instr_decode #(.DATAWIDTH(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_op_o      (dec_op_o),
    .dec_ra_o      (dec_ra_o),
    .dec_rb_o      (dec_rb_o),
    .dec_wreg_o    (dec_wreg_o),
    .dec_off_o     (dec_off_o),
    .dec_class_o   (dec_class_o),
    .dec_we_o      (dec_we_o),
    .illegal_cnt_o (illegal_cnt_o)
  );

  assign dut_b = '{op: dec_op_o, ra: dec_ra_o, rb: dec_rb_o, wreg: dec_wreg_o,
                   off: dec_off_o, cls: dec_class_o, we: dec_we_o};

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] ra,
                                      input logic [4:0] rb, input logic [4:0] rd,
                                      input logic [12:0] off);
    return {off, ra, rb, rd, op};
  endfunction

  // Reference decode written from the instruction-class rules.
  function automatic bundle_t ref_decode(input logic [31:0] ins);
    bundle_t     b;
    int          kind;
    logic [12:0] off13;
    logic [4:0]  rd;
    bit          bad;
    off13 = ins[31:19];
    rd    = ins[8:4];
    if (ins[3:0] <= XOR_) kind = 0;
    else if (ins[3:0] == LW || ins[3:0] == SW) kind = 1;
    else if (ins[3:0] >= BEQ && ins[3:0] <= BGE) kind = 2;
    else kind = 3;
    bad = (kind == 3) || (kind == 0 && off13 != 0) || ((kind == 1 || kind == 2) && rd != 0);
    b.op = ins[3:0];
    b.ra = ins[18:14];
    b.rb = ins[13:9];
    if (bad) begin
      b.cls = 2'd3; b.off = 0; b.wreg = 0; b.we = 1'b0;
    end else begin
      b.cls  = 2'(kind);
      b.off  = (kind == 0) ? 32'd0 :
               (off13[12] ? 32'(off13) - 32'd8192 : 32'(off13));
      b.wreg = (kind == 0) ? rd : (ins[3:0] == LW) ? ins[13:9] : 5'd0;
      b.we   = (kind == 0) || (ins[3:0] == LW);
    end
    return b;
  endfunction

  // Drives one cycle of inputs, advances one clock and updates the model; no checking here.
  task automatic tick(input logic rst, input logic v, input logic [31:0] ins, input logic dr,
                      input logic fl, output bit acc, output bit xfer);
    rst_i = rst; instr_valid_i = v; instr_i = ins; dec_ready_i = dr; flush_i = fl;
    acc  = !rst && v && m_ready && !fl;
    xfer = !rst && !fl && (q.size() > 0) && dr;
    @(posedge clk);
    if (rst) begin
      q.delete(); exp_cnt = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (xfer) begin
        if (q[0].cls == 2'd3 && exp_cnt != 16'hFFFF) exp_cnt++;
        void'(q.pop_front());
      end
      if (acc) q.push_back(ref_decode(ins));
    end
    m_ready = (q.size() < 2);
    #1;
  endtask

  task automatic test_reset;
    bit a, x;
    tick(1, 1, 32'hFFFF_FFF0, 0, 1, a, x);
    tick(1, 0, 0, 0, 0, a, x);
    checks++;
    if ({dec_valid_o, instr_ready_o, illegal_cnt_o} !== {1'b0, 1'b1, 16'd0}) begin
      failures++;
      $display("FAIL reset_ctrl: got v=%b r=%b cnt=%0d want v=0 r=1 cnt=0",
               dec_valid_o, instr_ready_o, illegal_cnt_o);
    end
    checks++;
    if (dut_b !== '0) begin
      failures++; $display("FAIL reset_data: got %h want 0", dut_b);
    end
  endtask

  task automatic test_decode;
    bit a, x;
    tick(0, 1, enc(ADD, 5'd1, 5'd3, 5'd22, 13'd0), 1, 0, a, x);
    checks++;
    if ({dec_valid_o, dec_class_o, dec_wreg_o, dec_we_o, dec_off_o} !==
        {1'b1, 2'd0, 5'd22, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL decode_add: got v=%b cls=%0d wreg=%0d we=%b off=%h want 1 0 22 1 0",
               dec_valid_o, dec_class_o, dec_wreg_o, dec_we_o, dec_off_o);
    end
    tick(0, 1, enc(LW, 5'd2, 5'd4, 5'd0, 13'h1FFF), 1, 0, a, x);
    checks++;
    if ({dec_class_o, dec_wreg_o, dec_we_o, dec_off_o} !== {2'd1, 5'd4, 1'b1, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL decode_lw: got cls=%0d wreg=%0d we=%b off=%h want 1 4 1 ffffffff",
               dec_class_o, dec_wreg_o, dec_we_o, dec_off_o);
    end
    tick(0, 1, enc(SW, 5'd2, 5'd4, 5'd0, 13'd16), 1, 0, a, x);
    checks++;
    if ({dec_class_o, dec_we_o, dec_off_o, dec_wreg_o} !== {2'd1, 1'b0, 32'd16, 5'd0}) begin
      failures++;
      $display("FAIL decode_sw: got cls=%0d we=%b off=%h wreg=%0d want 1 0 10 0",
               dec_class_o, dec_we_o, dec_off_o, dec_wreg_o);
    end
    tick(0, 0, 0, 1, 0, a, x);
    checks++;
    if (dec_valid_o !== 1'b0) begin
      failures++; $display("FAIL decode_drain: got v=%b want 0", dec_valid_o);
    end
  endtask

  task automatic test_illegal;
    bit a, x;
    logic [31:0] bad[3];
    bad[0] = enc(ADD, 5'd1, 5'd2, 5'd3, 13'd1);
    bad[1] = enc(BEQ, 5'd1, 5'd2, 5'd5, 13'd7);
    bad[2] = enc(4'd13, 5'd1, 5'd2, 5'd3, 13'd0);
    tick(1, 0, 0, 0, 0, a, x);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, bad[i], 1, 0, a, x);
      checks++;
      if ({dec_valid_o, dec_class_o, dec_we_o, dec_op_o} !== {1'b1, 2'd3, 1'b0, bad[i][3:0]}) begin
        failures++;
        $display("FAIL illegal_%0d: got v=%b cls=%0d we=%b op=%0d want 1 3 0 %0d",
                 i, dec_valid_o, dec_class_o, dec_we_o, dec_op_o, bad[i][3:0]);
      end
    end
    tick(0, 0, 0, 1, 0, a, x);
    checks++;
    if (illegal_cnt_o !== 16'd3) begin
      failures++; $display("FAIL illegal_cnt: got %0d want 3", illegal_cnt_o);
    end
  endtask

  task automatic test_backpressure;
    bit a, x;
    int k, popped, guard;
    logic [31:0] ins[5];
    for (int i = 0; i < 5; i++) ins[i] = enc(ADD, 5'(i), 5'(i + 7), 5'(i + 10), 13'd0);
    tick(1, 0, 0, 0, 0, a, x);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      tick(0, 1, ins[k], 0, 0, a, x);
      if (a) k++;
      checks++;
      if (dec_valid_o !== 1'b1 || dut_b !== ref_decode(ins[0])) begin
        failures++;
        $display("FAIL bp_stall_stable: got v=%b %h want 1 %h", dec_valid_o, dut_b,
                 ref_decode(ins[0]));
      end
    end
    checks++;
    if (k !== 2 || instr_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: got accepts=%0d ready=%b want 2 0", k, instr_ready_o);
    end
    popped = 0;
    guard = 0;
    while (popped < 5 && guard < 40) begin
      if (dec_valid_o) begin
        checks++;
        if (dut_b !== ref_decode(ins[popped])) begin
          failures++;
          $display("FAIL bp_order_%0d: got %h want %h", popped, dut_b, ref_decode(ins[popped]));
        end
      end
      tick(0, k < 5, (k < 5) ? ins[k] : 32'd0, 1, 0, a, x);
      if (a) k++;
      if (x) popped++;
      guard++;
    end
    checks++;
    if (popped !== 5 || dec_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: got popped=%0d v=%b want 5 0", popped, dec_valid_o);
    end
  endtask

  task automatic test_flush_reset;
    bit a, x;
    tick(1, 0, 0, 0, 0, a, x);
    tick(0, 1, enc(SUB, 5'd1, 5'd1, 5'd1, 13'd0), 0, 0, a, x);
    tick(0, 1, enc(MUL, 5'd2, 5'd2, 5'd2, 13'd0), 0, 0, a, x);
    tick(0, 1, enc(4'd14, 5'd3, 5'd3, 5'd3, 13'd0), 0, 1, a, x);
    checks++;
    if ({dec_valid_o, instr_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL flush: got v=%b r=%b want 0 1", dec_valid_o, instr_ready_o);
    end
    tick(0, 1, enc(BEQ, 5'd1, 5'd2, 5'd9, 13'd0), 1, 0, a, x);
    tick(0, 0, 0, 1, 0, a, x);
    tick(0, 1, enc(XOR_, 5'd4, 5'd5, 5'd6, 13'd0), 0, 0, a, x);
    tick(1, 1, enc(AND_, 5'd4, 5'd5, 5'd6, 13'd0), 1, 1, a, x);
    checks++;
    if ({dec_valid_o, instr_ready_o, illegal_cnt_o, dut_b} !== {1'b0, 1'b1, 16'd0, 54'd0}) begin
      failures++;
      $display("FAIL midreset: got v=%b r=%b cnt=%0d data=%h want 0 1 0 0",
               dec_valid_o, instr_ready_o, illegal_cnt_o, dut_b);
    end
    tick(0, 1, enc(OR_, 5'd7, 5'd8, 5'd9, 13'd0), 1, 0, a, x);
    checks++;
    if ({dec_valid_o, dut_b} !== {1'b1, ref_decode(enc(OR_, 5'd7, 5'd8, 5'd9, 13'd0))}) begin
      failures++; $display("FAIL post_reset: got v=%b %h", dec_valid_o, dut_b);
    end
  endtask

  task automatic test_random;
    bit a, x;
    logic [31:0] ins;
    logic [3:0]  op;
    tick(1, 0, 0, 0, 0, a, x);
    for (int c = 0; c < 600; c++) begin
      op  = 4'($urandom_range(0, 15));
      ins = $urandom;
      ins[3:0] = op;
      if ($urandom_range(0, 3) != 0) begin
        if (op <= XOR_) ins[31:19] = '0;
        else ins[8:4] = '0;
      end
      if ($urandom_range(0, 39) == 0) tick(0, 1, ins, 0, 1, a, x);
      else tick(0, $urandom_range(0, 2) != 0, ins, $urandom_range(0, 2) != 0, 0, a, x);
      checks++;
      if (dec_valid_o !== (q.size() > 0) || instr_ready_o !== m_ready ||
          illegal_cnt_o !== 16'(exp_cnt)) begin
        failures++;
        $display("FAIL rand_ctrl@%0d: got v=%b r=%b cnt=%0d want v=%b r=%b cnt=%0d", c,
                 dec_valid_o, instr_ready_o, illegal_cnt_o, q.size() > 0, m_ready, exp_cnt);
      end
      if (q.size() > 0) begin
        checks++;
        if (dut_b !== q[0]) begin
          failures++; $display("FAIL rand_data@%0d: got %h want %h", c, dut_b, q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_backpressure();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
